cmp_sched: RTL

Round-robin scheduler that shares one 32-bit signed subtract/compare datapath (`cmp_core`) among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester at a time, runs the subtraction, and returns the difference plus carry, overflow, equal and less-than flags on that requester's response channel. It sits between the CPU's branch/compare users (execute stage, address checker, etc.) and the single shared comparator.

---
 rtl/cmp_pkg.sv | 26 ++
 rtl/cmp_sched_if.sv | 31 +++
 rtl/cmp_core.sv | 24 ++
 rtl/cmp_sched.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared types and constants for the compare scheduler.
// Revision    : 1.0
// ============================================================================
package cmp_pkg;

    localparam int WIDTH = 32;
    localparam int NFLG  = 5;

    // Flag vector bit positions: {ltu, lt, eq, overflow, carry}
    localparam int FLG_C   = 0;
    localparam int FLG_V   = 1;
    localparam int FLG_EQ  = 2;
    localparam int FLG_LT  = 3;
    localparam int FLG_LTU = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cmp_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cmp_sched_if
// Description : Requester-side handshake bundle of the compare scheduler.
// Revision    : 1.0
// ============================================================================
interface cmp_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = cmp_pkg::WIDTH
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*WIDTH-1:0]    req_a;
    logic [NREQ*WIDTH-1:0]    req_b;
    logic [NREQ-1:0]          rsp_valid;
    logic [NREQ-1:0]          rsp_ready;
    logic [WIDTH-1:0]         rsp_out;
    logic [cmp_pkg::NFLG-1:0] rsp_flags;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_flags, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_flags, busy
    );
endinterface
`default_nettype wire

// File: rtl/cmp_core.sv
`default_nettype none
// ============================================================================
// Module      : cmp_core
// Description : Combinational two's-complement subtractor (A + ~B + 1).
// Revision    : 1.0
// ============================================================================
module cmp_core #(
    parameter int WIDTH = cmp_pkg::WIDTH
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_out,
    output logic                  o_carry,
    output logic                  o_overflow
);
    logic [WIDTH:0] w_sum;

    // Extra top bit captures the carry-out (set means no borrow)
    assign w_sum      = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
    assign o_out      = w_sum[WIDTH-1:0];
    assign o_carry    = w_sum[WIDTH];
    assign o_overflow = (i_a[WIDTH-1] ^ i_b[WIDTH-1]) & (o_out[WIDTH-1] ^ i_a[WIDTH-1]);
endmodule
`default_nettype wire

// File: rtl/cmp_sched.sv
`default_nettype none
// ============================================================================
// Module      : cmp_sched
// Description : Round-robin scheduler sharing one subtract/compare datapath.
// Revision    : 1.0
// ============================================================================
module cmp_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = cmp_pkg::WIDTH
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    cmp_sched_if.slave bus
);
    import cmp_pkg::*;

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_rr_ptr;
    logic [GW-1:0]     r_gnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_out;
    logic [NFLG-1:0]   r_flags;

    logic [GW:0]       w_pick;
    logic [GW-1:0]     w_sel;
    logic [GW-1:0]     w_ptr_nxt;
    logic              w_accept;
    logic              w_done;
    logic [NREQ-1:0]   w_req_ready;
    logic [NREQ-1:0]   w_rsp_valid;
    logic [WIDTH-1:0]  w_diff;
    logic              w_carry;
    logic              w_ovf;
    logic [NFLG-1:0]   w_flags;

    // Returns {found, index}: first valid at or above ptr, wrapping around
    function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [GW-1:0]   ptr);
        logic [GW:0] res;
        int          j;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!res[GW] && valid[j]) begin
                res = {1'b1, GW'(j)};
            end
        end
        return res;
    endfunction

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .i_a        (r_a),
        .i_b        (r_b),
        .o_out      (w_diff),
        .o_carry    (w_carry),
        .o_overflow (w_ovf)
    );

    always_comb begin
        w_flags          = '0;
        w_flags[FLG_C]   = w_carry;
        w_flags[FLG_V]   = w_ovf;
        w_flags[FLG_EQ]  = (w_diff == '0);
        w_flags[FLG_LT]  = w_diff[WIDTH-1] ^ w_ovf;
        w_flags[FLG_LTU] = ~w_carry;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_pick      = rr_pick(bus.req_valid, r_rr_ptr);
        w_sel       = w_pick[GW-1:0];
        w_ptr_nxt   = GW'((int'(r_gnt) + 1) % NREQ);
        case (r_state)
            IDLE: begin
                if (w_pick[GW]) begin
                    w_accept           = 1'b1;
                    w_req_ready[w_sel] = 1'b1;
                    w_state_nxt        = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                w_rsp_valid[r_gnt] = 1'b1;
                // Only the granted requester's ready bit can release the result
                if (bus.rsp_ready[r_gnt]) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_gnt <= w_sel;
                r_a   <= bus.req_a[int'(w_sel)*WIDTH +: WIDTH];
                r_b   <= bus.req_b[int'(w_sel)*WIDTH +: WIDTH];
            end
            if (r_state == EXEC) begin
                r_out   <= w_diff;
                r_flags <= w_flags;
            end
            if (w_done) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.req_ready = rst_n ? w_req_ready : '0;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_out   = r_out;
    assign bus.rsp_flags = r_flags;
    assign bus.busy      = (r_state != IDLE);
endmodule
`default_nettype wire
